// File: rtl/miss_arb_pkg.sv
// Shared types and helpers for the miss/fill arbiter: FSM state encoding,
// request opcode values and a constant-foldable ceil(log2) helper.
package miss_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam logic OP_FILL  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request picker: fixed priority (lowest index) or round-robin starting at ptr.
// Produces a one-hot winner, its index and an any-request flag.
module rr_arbiter
  import miss_arb_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned IDX_W   = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned      w_cand;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = 0;
    w_pos  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (RR_MODE != 0) begin
        w_cand = 32'(ptr) + k;
        if (w_cand >= N_CH) w_cand = w_cand - N_CH;
      end else begin
        w_cand = k;
      end
      w_pos = IDX_W'(w_cand);
      if (!any && req[w_pos]) begin
        any        = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/miss_fill_arbiter.sv
// Arbitrates N cache-miss requesters onto one pipelined memory: block fills
// issue one word per cycle and return in order; stores are single-word writes.
module miss_fill_arbiter
  import miss_arb_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned WORDS   = 8,
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          req_wr,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  output logic [N_CH-1:0]          grant,
  output logic                     fill_we,
  output logic [clog2(WORDS)-1:0]  fill_idx,
  output logic [DATA_W-1:0]        fill_data,
  output logic [N_CH-1:0]          done,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_valid
);

  localparam int unsigned IW    = clog2(WORDS);
  localparam int unsigned CW    = IW + 1;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = clog2(WORDS * BYTES);
  localparam int unsigned CH_W  = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || (DATA_W % 8) != 0) begin : g_param_check
    $error("miss_fill_arbiter: illegal parameter combination");
  end

  state_t           r_state, w_state_nxt;
  logic [N_CH-1:0]  r_grant;
  logic [CH_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]    r_iss_cnt, r_ret_cnt, w_ret_nxt;
  logic [N_CH-1:0]  w_arb_gnt;
  logic [CH_W-1:0]  w_arb_idx;
  logic             w_arb_any, w_take, w_fill_ok;

  rr_arbiter #(
    .N_CH   (N_CH),
    .RR_MODE(RR_MODE),
    .IDX_W  (CH_W)
  ) u_arb (
    .req(req),
    .ptr(r_ptr),
    .gnt(w_arb_gnt),
    .idx(w_arb_idx),
    .any(w_arb_any)
  );

  // Returns are only accepted while a fill is owned; stale data after reset is dropped.
  assign w_fill_ok = (r_state == ISSUE) || (r_state == DRAIN);
  assign fill_we   = w_fill_ok & mem_valid;
  assign fill_idx  = fill_we ? r_ret_cnt[IW-1:0] : '0;
  assign fill_data = fill_we ? mem_rdata : '0;
  assign w_ret_nxt = r_ret_cnt + CW'(fill_we);
  assign grant     = r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done        = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_take      = 1'b1;
          w_state_nxt = (req_wr[w_arb_idx] == OP_FILL) ? ISSUE : WRITE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = (r_addr & BLK_MASK) + ADDR_W'(r_iss_cnt[IW-1:0]) * ADDR_W'(BYTES);
        if (r_iss_cnt == CW'(WORDS - 1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_ret_nxt == CW'(WORDS)) w_state_nxt = DONE;
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = r_grant;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (w_take) begin
        r_grant   <= w_arb_gnt;
        r_addr    <= req_addr[w_arb_idx*ADDR_W +: ADDR_W];
        r_wdata   <= req_wdata[w_arb_idx*DATA_W +: DATA_W];
        r_iss_cnt <= '0;
        r_ret_cnt <= '0;
        r_ptr     <= (w_arb_idx == CH_W'(N_CH - 1)) ? '0 : w_arb_idx + 1'b1;
      end
      if (r_state == ISSUE) r_iss_cnt <= r_iss_cnt + 1'b1;
      if (fill_we)          r_ret_cnt <= w_ret_nxt;
      if (r_state == DONE) begin
        r_grant   <= '0;
        r_iss_cnt <= '0;
        r_ret_cnt <= '0;
      end
    end
  end

endmodule
